// File: rtl/am_pkg.sv
// Shared AM datapath definitions: sample format, control states and output saturation.
// Used by both the demodulator and the modulator path.
package am_pkg;

    localparam int AM_SAMPLE_W = 12;
    localparam int AM_WIDE_W   = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } am_state_e;

    localparam logic signed [AM_WIDE_W-1:0] AM_SAT_HI = 20'sd2047;
    localparam logic signed [AM_WIDE_W-1:0] AM_SAT_LO = -20'sd2048;

    function automatic logic signed [AM_SAMPLE_W-1:0] sat12(input logic signed [AM_WIDE_W-1:0] x);
        logic signed [AM_SAMPLE_W-1:0] y;
        if (x > AM_SAT_HI) begin
            y = 12'sh7ff;
        end else if (x < AM_SAT_LO) begin
            y = 12'sh800;
        end else begin
            y = x[AM_SAMPLE_W-1:0];
        end
        return y;
    endfunction

    // |x| with the most negative code folded onto full scale so it stays in 11 bits.
    function automatic logic [AM_SAMPLE_W-1:0] abs_sat(input logic signed [AM_SAMPLE_W-1:0] x);
        logic [AM_SAMPLE_W-1:0] y;
        if (x == 12'sh800) begin
            y = 12'h7ff;
        end else if (x < 0) begin
            y = AM_SAMPLE_W'(-x);
        end else begin
            y = x;
        end
        return y;
    endfunction

endpackage

// File: rtl/am_iir_lp.sv
// One-pole low-pass: acc += din - acc/2^SHIFT, output acc/2^SHIFT; updates only on upd.
// Latency 1 cycle from upd to new output; no backpressure, clr empties the accumulator.
module am_iir_lp #(
    parameter int IN_W  = 12,
    parameter int SHIFT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            upd,
    input  logic [IN_W-1:0] din,
    output logic [IN_W-1:0] dout
);

    localparam int ACC_W = IN_W + SHIFT;

    logic [ACC_W-1:0] acc;

    // Steady state is din * 2^SHIFT, so the unsigned accumulator never overflows.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
        end else if (upd) begin
            acc <= acc + ACC_W'(din) - (acc >> SHIFT);
        end
    end

    assign dout = acc[ACC_W-1:SHIFT];

endmodule

// File: rtl/am_demodulator.sv
// AM envelope demodulator: rectify, envelope low-pass, DC removal with lock indication.
// Latency 3 cycles valid-in to valid-out; no backpressure, i_enable low flushes everything.
module am_demodulator
    import am_pkg::*;
#(
    parameter int ENV_SHIFT = 4,
    parameter int DC_SHIFT  = 10,
    parameter int OUT_SHIFT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_valid,
    input  logic [AM_SAMPLE_W-1:0] i_amSignal,
    output logic [AM_SAMPLE_W-1:0] o_baseband,
    output logic                   o_valid,
    output logic                   o_locked
);

    localparam int CNT_W = DC_SHIFT + 1;
    localparam logic [CNT_W-1:0] SETTLE_N = {1'b1, {DC_SHIFT{1'b0}}};

    am_state_e state;
    am_state_e state_nxt;

    logic [CNT_W-1:0]       settle_cnt;
    logic                   clr;
    logic                   acc_vld;
    logic [AM_SAMPLE_W-1:0] rect;
    logic                   s1_vld;
    logic                   s2_vld;
    logic [AM_SAMPLE_W-1:0] env;
    logic [AM_SAMPLE_W-1:0] dc;
    logic signed [AM_WIDE_W-1:0] diff_w;

    assign clr     = !i_enable;
    assign acc_vld = i_valid && i_enable;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_locked  = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_N) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                o_locked = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!i_enable) begin
            state_nxt = IDLE;
        end
    end

    // Counts samples accepted while settling; holds at full scale rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && i_valid && settle_cnt != SETTLE_N) begin
            settle_cnt <= settle_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr) begin
            rect   <= '0;
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= acc_vld;
            if (acc_vld) begin
                rect <= abs_sat(i_amSignal);
            end
        end
    end

    am_iir_lp #(
        .IN_W  (AM_SAMPLE_W),
        .SHIFT (ENV_SHIFT)
    ) u_env_lp (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (clr),
        .upd   (s1_vld),
        .din   (rect),
        .dout  (env)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr) begin
            s2_vld <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
        end
    end

    // The DC tracker updates on the same edge the output is formed, so the
    // subtraction below sees the pre-update dc estimate.
    am_iir_lp #(
        .IN_W  (AM_SAMPLE_W),
        .SHIFT (DC_SHIFT)
    ) u_dc_lp (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (clr),
        .upd   (s2_vld),
        .din   (env),
        .dout  (dc)
    );

    assign diff_w = $signed(AM_WIDE_W'(env) - AM_WIDE_W'(dc)) <<< OUT_SHIFT;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || clr) begin
            o_baseband <= '0;
            o_valid    <= 1'b0;
        end else begin
            o_valid <= s2_vld;
            if (s2_vld) begin
                o_baseband <= sat12(diff_w);
            end
        end
    end

endmodule

// File: tb/tb_am_demodulator.sv
// Directed bench for am_demodulator at default parameters: reset, latency, rectifier
// saturation, lock timing, DC decay, flush on disable and 50% AM recovery.
module tb_am_demodulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        valid;
    logic [11:0] am;
    logic [11:0] bb;
    logic        ovld;
    logic        locked;

    int total = 0;
    int bad   = 0;

    logic [11:0] s30_in [3];
    int          s30_out [3];
    int          ring [16];
    int          rsum;
    int          ridx;
    int          mn;
    int          mx;
    int          mabs;
    int          v;
    int          iv;
    int          p2p;
    real         r;

    always #5 clk = ~clk;

    am_demodulator dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_enable   (enable),
        .i_valid    (valid),
        .i_amSignal (am),
        .o_baseband (bb),
        .o_valid    (ovld),
        .o_locked   (locked)
    );

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        s30_in[0]  = 12'h400;
        s30_in[1]  = 12'hc00;
        s30_in[2]  = 12'h400;
        s30_out[0] = 128;
        s30_out[1] = 248;
        s30_out[2] = 360;

        // Reset wins over enable and a toggling valid.
        rst_n  = 1'b0;
        enable = 1'b1;
        valid  = 1'b1;
        am     = 12'h400;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("rst_bb", $signed(bb), 0);
            check_eq("rst_vld", ovld, 0);
            check_eq("rst_lock", locked, 0);
            valid = ~valid;
        end
        rst_n  = 1'b1;
        enable = 1'b0;
        valid  = 1'b0;
        step();

        // Enable rises with the first sample; three back-to-back samples, one negative.
        enable = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            valid = (e <= 3);
            if (e <= 3) am = s30_in[e-1];
            step();
            check_eq($sformatf("lat_vld_e%0d", e), ovld, (e >= 3 && e <= 5));
            if (e >= 3 && e <= 5) check_eq($sformatf("lat_bb_e%0d", e), $signed(bb), s30_out[e-3]);
        end
        check_eq("lat_lock", locked, 0);
        enable = 1'b0;
        step();
        check_eq("clr_bb", $signed(bb), 0);

        // Most negative input rectifies to full scale and the envelope converges without wrap.
        enable = 1'b1;
        valid  = 1'b1;
        am     = 12'h800;
        for (int n = 1; n <= 400; n++) begin
            step();
            if (n == 3) check_eq("neg_first_bb", $signed(bb), 254);
        end
        check_eq("neg_env_conv", (dut.env >= 12'd2046 && dut.env <= 12'd2047), 1);
        check_eq("neg_bb_sat", $signed(bb), 2047);
        enable = 1'b0;
        step();

        // Constant input: lock after the settle window, output decays to zero.
        enable = 1'b1;
        valid  = 1'b1;
        am     = 12'h100;
        for (int n = 1; n <= 8300; n++) begin
            step();
            if (n == 1020) check_eq("dc_lock_early", locked, 0);
            if (n == 1030) check_eq("dc_lock_late", locked, 1);
        end
        v = $signed(bb);
        check_eq("dc_decay", (v >= -2 && v <= 2), 1);

        // Drop enable with the pipeline full.
        enable = 1'b0;
        step();
        check_eq("drop_vld", ovld, 0);
        check_eq("drop_lock", locked, 0);
        check_eq("drop_bb", $signed(bb), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("drop_vld_%0d", i), ovld, 0);
        end

        // Re-enable: clean pipeline and a fresh settle count.
        enable = 1'b1;
        am     = 12'h400;
        for (int n = 1; n <= 1030; n++) begin
            step();
            if (n == 2) check_eq("re_cnt", dut.settle_cnt, 1);
            if (n == 3) check_eq("re_first_bb", $signed(bb), 128);
            if (n == 1020) check_eq("re_lock_early", locked, 0);
            if (n == 1030) check_eq("re_lock_late", locked, 1);
        end
        enable = 1'b0;
        valid  = 1'b0;
        step();

        // 50% AM on a 16-sample carrier; a 16-sample average removes carrier ripple.
        for (int i = 0; i < 16; i++) ring[i] = 0;
        rsum   = 0;
        ridx   = 0;
        mn     = 1 << 30;
        mx     = -(1 << 30);
        mabs   = 0;
        enable = 1'b1;
        valid  = 1'b1;
        for (int n = 0; n < 9216; n++) begin
            r  = 512.0 * (1.0 + 0.5 * $sin(6.283185307179586 * n / 1024.0))
                       * $sin(6.283185307179586 * n / 16.0);
            iv = $rtoi(r);
            am = iv[11:0];
            step();
            if (ovld) begin
                v          = $signed(bb);
                rsum       = rsum + v - ring[ridx];
                ring[ridx] = v;
                ridx       = (ridx + 1) % 16;
                if (n >= 8192) begin
                    if (rsum < mn) mn = rsum;
                    if (rsum > mx) mx = rsum;
                    if (v > mabs) mabs = v;
                    if (-v > mabs) mabs = -v;
                end
            end
        end
        p2p = (mx - mn) / 16;
        check_eq("am_p2p_range", (p2p >= 570 && p2p <= 700), 1);
        check_eq("am_no_sat", (mabs < 2047), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
